// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: frame geometry, common scan codes, receiver state encoding.
// Also imported by the downstream scan-code decoder.
package ps2_pkg;

   localparam int unsigned PS2_FRAME_BITS = 11;
   localparam logic [7:0]  PS2_BREAK      = 8'hF0;
   localparam logic [7:0]  PS2_EXT        = 8'hE0;

   typedef enum logic [1:0] {
      StIdle,
      StShift,
      StCheck
   } rx_state_e;

   // Odd parity over eight data bits plus the parity bit.
   function automatic logic odd_parity_ok(input logic [8:0] bits);
      return ^bits;
   endfunction

endpackage

// File: rtl/ps2_byte_fifo.sv
// Byte FIFO for received scan codes. Holds the full-with-pop write rule and the
// simultaneous push/pop rule; pointers wrap modulo DEPTH (power of two).
module ps2_byte_fifo
   import ps2_pkg::*;
#(
   parameter int unsigned DEPTH = 8
) (
   input  logic       clk,
   input  logic       clrn,
   input  logic       push,
   input  logic [7:0] wdata,
   input  logic       pop,
   output logic [7:0] rdata,
   output logic       full,
   output logic       empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [AW:0]   count;
   logic          pop_ok;
   logic          push_ok;

   // A pop frees the slot the same cycle, so a full FIFO still accepts a push then.
   always_comb begin
      empty   = (count == '0);
      full    = (count == CNT_FULL);
      pop_ok  = pop & ~empty;
      push_ok = push & (~full | pop_ok);
      rdata   = mem[rd_ptr];
   end

   // Storage, pointers and occupancy count.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i] <= 8'h00;
         end
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver with scan-code FIFO.
// Optional macro PS2_PARITY_CHECK_EN: when defined, frames with bad odd parity are rejected.
module ps2_rx_fifo
   import ps2_pkg::*;
#(
   parameter int unsigned DEPTH       = 8,
   parameter int unsigned SYNC_STAGES = 3,
   parameter int unsigned TIMEOUT_CYC = 100000
) (
   input  logic       clk,
   input  logic       clrn,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic       nextdata_n,
   output logic [7:0] data,
   output logic       ready,
   output logic       overflow,
   output logic       frame_err
);

   localparam int unsigned TW       = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
   // Bits after the start bit: 8 data, parity, stop.
   localparam logic [3:0] BIT_LAST = 4'(PS2_FRAME_BITS - 2);

   logic [SYNC_STAGES-1:0] clk_sync;
   logic [SYNC_STAGES-1:0] dat_sync;
   logic                   clk_prev;
   logic                   clk_s;
   logic                   dat_s;
   logic                   fall;

   rx_state_e state, state_d;
   logic [3:0]    bitcnt, bitcnt_d;
   logic [9:0]    shreg, shreg_d;
   logic [TW-1:0] tmo, tmo_d;
   logic          frame_ok;
   logic          push;
   logic          pop_req;
   logic          fifo_full;
   logic          fifo_empty;
   logic          overflow_q;

   // Synchronisers idle high so reset never looks like a falling edge.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         clk_sync <= '1;
         dat_sync <= '1;
         clk_prev <= 1'b1;
      end else begin
         clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
         dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_data};
         clk_prev <= clk_sync[SYNC_STAGES-1];
      end
   end

   assign clk_s = clk_sync[SYNC_STAGES-1];
   assign dat_s = dat_sync[SYNC_STAGES-1];
   assign fall  = clk_prev & ~clk_s;

   // After the full frame: shreg[7:0] data, shreg[8] parity, shreg[9] stop.
   always_comb begin
`ifdef PS2_PARITY_CHECK_EN
      frame_ok = shreg[9] & odd_parity_ok(shreg[8:0]);
`else
      frame_ok = shreg[9];
`endif
   end

   // Receive FSM next state, bit shifting, timeout and frame verdict.
   always_comb begin
      state_d   = state;
      bitcnt_d  = bitcnt;
      shreg_d   = shreg;
      tmo_d     = tmo;
      push      = 1'b0;
      frame_err = 1'b0;
      unique case (state)
         StIdle: begin
            if (fall && !dat_s) begin
               state_d  = StShift;
               bitcnt_d = '0;
               tmo_d    = '0;
            end
         end
         StShift: begin
            if (fall) begin
               shreg_d = {dat_s, shreg[9:1]};
               tmo_d   = '0;
               if (bitcnt == BIT_LAST) begin
                  state_d = StCheck;
               end else begin
                  bitcnt_d = bitcnt + 1'b1;
               end
            end else if (tmo == TMO_LAST) begin
               state_d   = StIdle;
               frame_err = 1'b1;
            end else begin
               tmo_d = tmo + 1'b1;
            end
         end
         StCheck: begin
            state_d = StIdle;
            if (frame_ok) begin
               push = 1'b1;
            end else begin
               frame_err = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Receive FSM registers.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state  <= StIdle;
         bitcnt <= '0;
         shreg  <= '0;
         tmo    <= '0;
      end else begin
         state  <= state_d;
         bitcnt <= bitcnt_d;
         shreg  <= shreg_d;
         tmo    <= tmo_d;
      end
   end

   assign ready   = ~fifo_empty;
   assign pop_req = ready & ~nextdata_n;

   // Sticky drop flag: a good frame arrived with no room and no pop to make room.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         overflow_q <= 1'b0;
      end else if (push && fifo_full && !pop_req) begin
         overflow_q <= 1'b1;
      end
   end

   assign overflow = overflow_q;

   ps2_byte_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .clrn  (clrn),
      .push  (push),
      .wdata (shreg[7:0]),
      .pop   (pop_req),
      .rdata (data),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Bench for ps2_rx_fifo: table of frames/pops, hand-written corner sequences,
// then randomized frames against a queue-based reference model.
module tb_ps2_rx_fifo;

   localparam int DEPTH = 8;
   localparam int SYNC  = 3;
   localparam int TMO   = 300;
   localparam int HALF  = 8;

   logic       clk = 1'b0;
   logic       clrn = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic       nextdata_n = 1'b1;
   logic [7:0] data;
   logic       ready;
   logic       overflow;
   logic       frame_err;

   int vectors = 0;
   int miscompares = 0;
   int ferr_cnt = 0;

   logic [7:0] model_q[$];
   logic       model_ovf;

   ps2_rx_fifo #(
      .DEPTH       (DEPTH),
      .SYNC_STAGES (SYNC),
      .TIMEOUT_CYC (TMO)
   ) dut (
      .clk        (clk),
      .clrn       (clrn),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .nextdata_n (nextdata_n),
      .data       (data),
      .ready      (ready),
      .overflow   (overflow),
      .frame_err  (frame_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (frame_err === 1'b1) ferr_cnt++;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   typedef struct {
      bit         send;
      logic [7:0] b;
      logic       stop;
      logic       par_bad;
      int         pops;
      logic       exp_ready;
      bit         chk_data;
      logic [7:0] exp_data;
      int         exp_ferr;
      logic       exp_ovf;
   } vec_t;

   vec_t tbl[9];

   task automatic wait_neg(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      ps2_data = b;
      wait_neg(HALF);
      ps2_clk = 1'b0;
      wait_neg(HALF);
      ps2_clk = 1'b1;
   endtask

   // Full 11-bit frame; optionally pulse a pop in the cycle the stop bit is checked.
   task automatic send_frame(input logic [7:0] b, input logic stop, input logic par_bad,
                             input bit pop_at_check);
      logic par;
      par = (~^b) ^ par_bad;
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit(par);
      ps2_data = stop;
      wait_neg(HALF);
      ps2_clk = 1'b0;
      if (pop_at_check) begin
         // Fall seen after SYNC flops + edge register; check cycle follows.
         wait_neg(SYNC + 1);
         nextdata_n = 1'b0;
         wait_neg(1);
         nextdata_n = 1'b1;
         wait_neg(HALF - SYNC - 2);
      end else begin
         wait_neg(HALF);
      end
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      wait_neg(4);
   endtask

   task automatic pop_one();
      nextdata_n = 1'b0;
      wait_neg(1);
      nextdata_n = 1'b1;
      wait_neg(1);
   endtask

   task automatic do_reset();
      clrn = 1'b0;
      wait_neg(2);
      clrn = 1'b1;
      wait_neg(2);
      model_q.delete();
      model_ovf = 1'b0;
   endtask

   function automatic bit frame_valid(input logic stop, input logic par_bad);
`ifdef PS2_PARITY_CHECK_EN
      return stop && !par_bad;
`else
      return bit'(stop);
`endif
   endfunction

   initial begin
      int f0;
      wait_neg(1);
      // Reset values while clrn is low.
      check("reset_ready", 32'(ready), 32'd0);
      check("reset_data", 32'(data), 32'h00);
      check("reset_overflow", 32'(overflow), 32'd0);
      check("reset_frame_err", 32'(frame_err), 32'd0);
      do_reset();

      // ---------------- table-driven vectors ----------------
      tbl[0] = '{1'b1, 8'h1C, 1'b1, 1'b0, 0, 1'b1, 1'b1, 8'h1C, 0, 1'b0};
      tbl[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b0, 1'b0, 8'h00, 0, 1'b0};
      tbl[2] = '{1'b1, 8'hF0, 1'b1, 1'b0, 0, 1'b1, 1'b1, 8'hF0, 0, 1'b0};
      tbl[3] = '{1'b1, 8'h1C, 1'b1, 1'b0, 0, 1'b1, 1'b1, 8'hF0, 0, 1'b0};
      tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b1, 1'b1, 8'h1C, 0, 1'b0};
      tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b0, 1'b0, 8'h00, 0, 1'b0};
      tbl[6] = '{1'b1, 8'h1C, 1'b0, 1'b0, 0, 1'b0, 1'b0, 8'h00, 1, 1'b0};
`ifdef PS2_PARITY_CHECK_EN
      tbl[7] = '{1'b1, 8'h1C, 1'b1, 1'b1, 0, 1'b0, 1'b0, 8'h00, 1, 1'b0};
`else
      tbl[7] = '{1'b1, 8'h1C, 1'b1, 1'b1, 0, 1'b1, 1'b1, 8'h1C, 0, 1'b0};
`endif
      // One pop; in the parity-checked build this is a pop on an empty FIFO.
      tbl[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b0, 1'b0, 8'h00, 0, 1'b0};

      for (int i = 0; i < 9; i++) begin
         f0 = ferr_cnt;
         if (tbl[i].send) send_frame(tbl[i].b, tbl[i].stop, tbl[i].par_bad, 1'b0);
         for (int p = 0; p < tbl[i].pops; p++) pop_one();
         check($sformatf("tbl%0d_ready", i), 32'(ready), 32'(tbl[i].exp_ready));
         if (tbl[i].chk_data) check($sformatf("tbl%0d_data", i), 32'(data), 32'(tbl[i].exp_data));
         check($sformatf("tbl%0d_frame_err", i), 32'(ferr_cnt - f0), 32'(tbl[i].exp_ferr));
         check($sformatf("tbl%0d_overflow", i), 32'(overflow), 32'(tbl[i].exp_ovf));
      end

      // ---------------- overflow: DEPTH+1 frames, no pops ----------------
      do_reset();
      for (int i = 0; i <= DEPTH; i++) send_frame(8'(8'h20 + i), 1'b1, 1'b0, 1'b0);
      check("ovf_ready", 32'(ready), 32'd1);
      check("ovf_head", 32'(data), 32'h20);
      check("ovf_flag", 32'(overflow), 32'd1);
      pop_one();
      check("ovf_sticky", 32'(overflow), 32'd1);
      for (int i = 1; i < DEPTH; i++) begin
         check($sformatf("ovf_order%0d", i), 32'(data), 32'(8'h20 + i));
         pop_one();
      end
      check("ovf_last_absent", 32'(ready), 32'd0);

      // ---------------- reset mid-frame ----------------
      send_frame(8'h33, 1'b1, 1'b0, 1'b0);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      clrn = 1'b0;
      wait_neg(2);
      check("midrst_ready", 32'(ready), 32'd0);
      check("midrst_data", 32'(data), 32'h00);
      check("midrst_overflow", 32'(overflow), 32'd0);
      check("midrst_frame_err", 32'(frame_err), 32'd0);
      clrn = 1'b1;
      wait_neg(2);
      send_frame(8'h12, 1'b1, 1'b0, 1'b0);
      check("midrst_next_ready", 32'(ready), 32'd1);
      check("midrst_next_data", 32'(data), 32'h12);
      pop_one();

      // ---------------- full FIFO with pop in the check cycle ----------------
      do_reset();
      for (int i = 0; i < DEPTH; i++) send_frame(8'(8'h40 + i), 1'b1, 1'b0, 1'b0);
      check("fullpop_pre_ovf", 32'(overflow), 32'd0);
      send_frame(8'h55, 1'b1, 1'b0, 1'b1);
      check("fullpop_ovf", 32'(overflow), 32'd0);
      for (int i = 1; i <= DEPTH; i++) begin
         check($sformatf("fullpop_order%0d", i), 32'(data),
               (i < DEPTH) ? 32'(8'h40 + i) : 32'h55);
         pop_one();
      end
      check("fullpop_empty", 32'(ready), 32'd0);

      // ---------------- timeout mid-frame ----------------
      f0 = ferr_cnt;
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      wait_neg(TMO - 40);
      check("tmo_not_early", 32'(ferr_cnt - f0), 32'd0);
      wait_neg(60);
      check("tmo_frame_err", 32'(ferr_cnt - f0), 32'd1);
      check("tmo_no_push", 32'(ready), 32'd0);
      send_frame(8'h12, 1'b1, 1'b0, 1'b0);
      check("tmo_next_ready", 32'(ready), 32'd1);
      check("tmo_next_data", 32'(data), 32'h12);
      check("tmo_next_noerr", 32'(ferr_cnt - f0), 32'd1);
      pop_one();

      // ---------------- randomized frames vs reference model ----------------
      do_reset();
      for (int n = 0; n < 40; n++) begin
         logic [7:0] b;
         logic       stop;
         logic       pbad;
         int         pops;
         b    = 8'($urandom);
         stop = ($urandom_range(0, 7) != 0);
         pbad = ($urandom_range(0, 7) == 0);
         f0   = ferr_cnt;
         send_frame(b, stop, pbad, 1'b0);
         if (frame_valid(stop, pbad)) begin
            if (model_q.size() < DEPTH) model_q.push_back(b);
            else model_ovf = 1'b1;
         end
         check($sformatf("rnd%0d_frame_err", n), 32'(ferr_cnt - f0),
               frame_valid(stop, pbad) ? 32'd0 : 32'd1);
         check($sformatf("rnd%0d_ready", n), 32'(ready), 32'(model_q.size() != 0));
         if (model_q.size() != 0) check($sformatf("rnd%0d_data", n), 32'(data), 32'(model_q[0]));
         check($sformatf("rnd%0d_overflow", n), 32'(overflow), 32'(model_ovf));
         pops = ($urandom_range(0, 9) < 4) ? $urandom_range(1, 2) : 0;
         for (int p = 0; p < pops; p++) begin
            pop_one();
            if (model_q.size() != 0) void'(model_q.pop_front());
         end
         check($sformatf("rnd%0d_ready_after_pop", n), 32'(ready), 32'(model_q.size() != 0));
         if (model_q.size() != 0) begin
            check($sformatf("rnd%0d_data_after_pop", n), 32'(data), 32'(model_q[0]));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
